// File: rtl/jhash_pkg.sv
// Shared definitions for the jhash stream feeder: FSM states, group size
// and the stream_left encodings.
package jhash_pkg;

    localparam int unsigned GROUP_WORDS = 3;

    // Collect count value meaning "all three lanes filled".
    localparam logic [1:0] COUNT_FULL = 2'd3;

    // stream_left value presented on a non-final group.
    localparam logic [1:0] LEFT_NONFINAL = 2'b11;

    // stream_left value while no group is presented.
    localparam logic [1:0] LEFT_IDLE = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_DONE
    } feed_state_t;

endpackage

// File: rtl/jhash_group_buf.sv
// Three-word collect register for the jhash feeder. Holds the words of the
// group being assembled, how many are valid, and whether the message ended.
module jhash_group_buf
    import jhash_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        take,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        set_last,
    output logic [31:0] word0,
    output logic [31:0] word1,
    output logic [31:0] word2,
    output logic [1:0]  count,
    output logic        last,
    output logic        complete
);

    logic [31:0] words [GROUP_WORDS];
    logic [1:0]  wr_idx;

    // A beat arriving in the same cycle the group is taken lands in lane 0.
    always_comb begin
        wr_idx = take ? 2'd0 : count;
    end

    // Collect storage: take empties the buffer, a write appends one word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words <= '{default: '0};
            count <= '0;
            last  <= 1'b0;
        end else if (clr) begin
            words <= '{default: '0};
            count <= '0;
            last  <= 1'b0;
        end else begin
            if (wr_en) begin
                words[wr_idx] <= wr_data;
            end
            if (take) begin
                count <= wr_en ? 2'd1 : 2'd0;
            end else if (wr_en) begin
                count <= count + 2'd1;
            end
            last <= (take ? 1'b0 : last) | set_last;
        end
    end

    assign word0    = words[0];
    assign word1    = words[1];
    assign word2    = words[2];
    assign complete = (count == COUNT_FULL) || last;

endmodule

// File: rtl/jhash_feed.sv
// Upstream feeder for the jhash core: packs the word stream into 3-word
// groups, double-buffered behind an output slot with a valid/ack handshake,
// and flags end-of-message with stream_done / stream_left.
module jhash_feed
    import jhash_pkg::*;
#(
    parameter logic [31:0] PAD_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_empty,
    output logic        in_ready,
    output logic [31:0] stream_data0,
    output logic [31:0] stream_data1,
    output logic [31:0] stream_data2,
    output logic        stream_valid,
    input  logic        stream_ack,
    output logic        stream_done,
    output logic [1:0]  stream_left
);

    feed_state_t state;
    feed_state_t state_next;

    logic        accept;
    logic        beat_empty;
    logic        ack_eff;
    logic        transfer;

    logic [31:0] buf_word0;
    logic [31:0] buf_word1;
    logic [31:0] buf_word2;
    logic [1:0]  buf_count;
    logic        buf_last;
    logic        buf_complete;

    logic        slot_full;
    logic        slot_final;
    logic [1:0]  slot_count;
    logic [31:0] slot_data0;
    logic [31:0] slot_data1;
    logic [31:0] slot_data2;

    // Handshake qualifiers; in_empty only counts on a last beat.
    always_comb begin
        beat_empty = in_empty & in_last;
        accept     = in_valid & in_ready;
        ack_eff    = stream_ack & slot_full;
        transfer   = buf_complete & (~slot_full | ack_eff);
    end

    jhash_group_buf u_group_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .take     (transfer),
        .wr_en    (accept & ~beat_empty),
        .wr_data  (in_data),
        .set_last (accept & in_last),
        .word0    (buf_word0),
        .word1    (buf_word1),
        .word2    (buf_word2),
        .count    (buf_count),
        .last     (buf_last),
        .complete (buf_complete)
    );

    // Output slot: loads a padded group on transfer, empties on a bare ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full  <= 1'b0;
            slot_final <= 1'b0;
            slot_count <= '0;
            slot_data0 <= PAD_VALUE;
            slot_data1 <= PAD_VALUE;
            slot_data2 <= PAD_VALUE;
        end else if (clr) begin
            slot_full  <= 1'b0;
            slot_final <= 1'b0;
            slot_count <= '0;
            slot_data0 <= PAD_VALUE;
            slot_data1 <= PAD_VALUE;
            slot_data2 <= PAD_VALUE;
        end else if (transfer) begin
            slot_full  <= 1'b1;
            slot_final <= buf_last;
            slot_count <= buf_count;
            slot_data0 <= (buf_count >= 2'd1) ? buf_word0 : PAD_VALUE;
            slot_data1 <= (buf_count >= 2'd2) ? buf_word1 : PAD_VALUE;
            slot_data2 <= (buf_count == COUNT_FULL) ? buf_word2 : PAD_VALUE;
        end else if (ack_eff) begin
            slot_full <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; clr wins over every other event.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && in_last) begin
                        state_next = S_DRAIN;
                    end else if (accept) begin
                        state_next = S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept && in_last) begin
                        state_next = S_DRAIN;
                    end else if (!accept && buf_count == 2'd0 && !slot_full) begin
                        state_next = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (ack_eff && slot_final) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    state_next = S_DONE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // FSM outputs and stream presentation.
    always_comb begin
        in_ready     = !buf_complete && (state != S_DRAIN) && (state != S_DONE);
        stream_valid = slot_full;
        stream_done  = (state == S_DONE);
        if (!slot_full) begin
            stream_left = LEFT_IDLE;
        end else if (slot_final) begin
            stream_left = slot_count;
        end else begin
            stream_left = LEFT_NONFINAL;
        end
        stream_data0 = slot_data0;
        stream_data1 = slot_data1;
        stream_data2 = slot_data2;
    end

endmodule
